// File: rtl/vga_scanout.sv
// Pixel-plot framebuffer (160x120x3) with 640x480@60Hz VGA scan-out in 4x4 blocks,
// a post-reset background clear, and a one-clock pulse at the start of vertical blank.
module vga_scanout #(
  parameter logic [2:0] BG_COLOUR      = 3'b000,
  parameter logic       CLEAR_ON_RESET = 1'b1,
  parameter int         H_VISIBLE      = 640,
  parameter int         H_FRONT        = 16,
  parameter int         H_SYNC         = 96,
  parameter int         H_BACK         = 48,
  parameter int         V_VISIBLE      = 480,
  parameter int         V_FRONT        = 10,
  parameter int         V_SYNC         = 2,
  parameter int         V_BACK         = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       busy,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);

  localparam logic [9:0]  H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0]  H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0]  HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  HS_STOP   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0]  V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_STOP   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [14:0] FB_LAST   = 15'd19199;
  localparam logic [7:0]  X_LIMIT   = 8'd160;
  localparam logic [6:0]  Y_LIMIT   = 7'd120;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [14:0] clr_addr_r;
  logic        clear_we_s;

  logic        pix_en_r, vga_clk_r;
  logic [9:0]  hcount_r, vcount_r;
  logic        hs_raw_s, vs_raw_s, blank_raw_s;
  logic [14:0] rd_addr_s, rd_addr_r;
  logic        hs1_r, vs1_r, blank1_r;
  logic [2:0]  rd_data_r;
  logic        we_s;
  logic [14:0] wa_s;
  logic [2:0]  wd_s;
  logic        hs2_r, vs2_r, blank2_r, frame_start_r;
  logic [9:0]  r_r, g_r, b_r;

  logic [2:0]  mem [0:19199];

  // Pixel enable at half the system clock, plus the visible pixel clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_en_r  <= 1'b0;
      vga_clk_r <= 1'b0;
    end else begin
      pix_en_r  <= ~pix_en_r;
      vga_clk_r <= ~pix_en_r;
    end
  end

  // Horizontal and vertical raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_r <= 10'd0;
      vcount_r <= 10'd0;
    end else if (pix_en_r) begin
      if (hcount_r == H_LAST) begin
        hcount_r <= 10'd0;
        vcount_r <= (vcount_r == V_LAST) ? 10'd0 : vcount_r + 10'd1;
      end else begin
        hcount_r <= hcount_r + 10'd1;
      end
    end
  end

  // Raw sync/blank decode and framebuffer read address (y*160 = y*128 + y*32)
  always_comb begin
    hs_raw_s    = !((hcount_r >= HS_START) && (hcount_r < HS_STOP));
    vs_raw_s    = !((vcount_r >= VS_START) && (vcount_r < VS_STOP));
    blank_raw_s = (hcount_r < H_VIS_END) && (vcount_r < V_VIS_END);
    rd_addr_s   = ({8'd0, vcount_r[8:2]} << 3'd7) + ({8'd0, vcount_r[8:2]} << 3'd5)
                + {7'd0, hcount_r[9:2]};
  end

  // Stage 1: address and raw timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_r <= 15'd0;
      hs1_r     <= 1'b1;
      vs1_r     <= 1'b1;
      blank1_r  <= 1'b0;
    end else if (pix_en_r) begin
      rd_addr_r <= rd_addr_s;
      hs1_r     <= hs_raw_s;
      vs1_r     <= vs_raw_s;
      blank1_r  <= blank_raw_s;
    end
  end

  // Write port mux: the clear owns the port while busy, otherwise in-range plots
  always_comb begin
    we_s = 1'b0;
    wa_s = 15'd0;
    wd_s = 3'b000;
    if (clear_we_s) begin
      we_s = 1'b1;
      wa_s = clr_addr_r;
      wd_s = BG_COLOUR;
    end else if (plot && (x < X_LIMIT) && (y < Y_LIMIT)) begin
      we_s = 1'b1;
      wa_s = ({8'd0, y} << 3'd7) + ({8'd0, y} << 3'd5) + {7'd0, x};
      wd_s = colour;
    end else begin
      we_s = 1'b0;
    end
  end

  // Framebuffer RAM; a same-address read in the write cycle returns the old word
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[wa_s] <= wd_s;
    end
    rd_data_r <= mem[rd_addr_r];
  end

  // Stage 2: colour and delayed timing, plus the vertical-blank pacing pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs2_r         <= 1'b1;
      vs2_r         <= 1'b1;
      blank2_r      <= 1'b0;
      r_r           <= 10'd0;
      g_r           <= 10'd0;
      b_r           <= 10'd0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pix_en_r && (hcount_r == 10'd0) && (vcount_r == V_VIS_END);
      if (pix_en_r) begin
        hs2_r    <= hs1_r;
        vs2_r    <= vs1_r;
        blank2_r <= blank1_r;
        r_r      <= blank1_r ? {10{rd_data_r[2]}} : 10'd0;
        g_r      <= blank1_r ? {10{rd_data_r[1]}} : 10'd0;
        b_r      <= blank1_r ? {10{rd_data_r[0]}} : 10'd0;
      end
    end
  end

  // Clear FSM state register and clear address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_addr_r <= 15'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == CLEAR) begin
        clr_addr_r <= (clr_addr_r == FB_LAST) ? 15'd0 : clr_addr_r + 15'd1;
      end
    end
  end

  // Clear FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = IDLE;
      CLEAR:   state_nxt_s = (clr_addr_r == FB_LAST) ? IDLE : CLEAR;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Clear FSM outputs
  always_comb begin
    clear_we_s = 1'b0;
    case (state_r)
      IDLE:    clear_we_s = 1'b0;
      CLEAR:   clear_we_s = 1'b1;
      default: clear_we_s = 1'b0;
    endcase
  end

  assign busy        = clear_we_s;
  assign frame_start = frame_start_r;
  assign VGA_CLK     = vga_clk_r;
  assign VGA_HS      = hs2_r;
  assign VGA_VS      = vs2_r;
  assign VGA_BLANK_N = blank2_r;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_r;
  assign VGA_G       = g_r;
  assign VGA_B       = b_r;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-geometry instance and a shrunken-raster instance share one
// plot stream; every output is compared each clock against a raster/framebuffer model.
module tb_vga_scanout;

  localparam int         FB_WORDS   = 19200;
  localparam int         CLEAR_CLKS = 19200;
  localparam logic [2:0] BG         = 3'b000;
  // shrunken raster: 80 px x 15 lines per frame
  localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVV = 8,  SVF = 2, SVS = 2, SVB = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] x = 8'd0;
  logic [6:0] y = 7'd0;
  logic [2:0] colour = 3'b000;
  logic       plot = 1'b0;

  logic       b_busy, b_fs, b_vclk, b_hs, b_vs, b_bn, b_sn;
  logic [9:0] b_r, b_g, b_b;
  logic       s_busy, s_fs, s_vclk, s_hs, s_vs, s_bn, s_sn;
  logic [9:0] s_r, s_g, s_b;
  logic [36:0] b_obs, s_obs;

  int cmp_cnt = 0;
  int fail_cnt = 0;
  int n_edge = 0;

  logic [2:0] cur_v  [FB_WORDS];
  logic [2:0] prev_v [FB_WORDS];
  bit         cur_k  [FB_WORDS];
  bit         prev_k [FB_WORDS];
  int         wedge  [FB_WORDS];

  vga_scanout u_big (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(b_busy), .frame_start(b_fs), .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b)
  );

  vga_scanout #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(s_busy), .frame_start(s_fs), .VGA_CLK(s_vclk), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
  );

  assign b_obs = {b_vclk, b_hs, b_vs, b_bn, b_sn, b_busy, b_fs, b_r, b_g, b_b};
  assign s_obs = {s_vclk, s_hs, s_vs, s_bn, s_sn, s_busy, s_fs, s_r, s_g, s_b};

  always #10 clk = ~clk;

  // clk edges since the last reset release
  always @(posedge clk or posedge reset) begin
    if (reset) n_edge <= 0;
    else       n_edge <= n_edge + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reset: prior contents no longer trusted, clear writes address a on edge a+1
  task automatic model_reset();
    for (int a = 0; a < FB_WORDS; a++) begin
      prev_k[a] = 1'b0;
      prev_v[a] = BG;
      cur_v[a]  = BG;
      cur_k[a]  = 1'b1;
      wedge[a]  = a + 1;
    end
  endtask

  // Word visible to a colour launched at stage-2 edge m (write must precede edge m-1)
  function automatic void cell_at(input int a, input int m, output logic [2:0] c, output bit k);
    if (wedge[a] <= m - 2) begin
      c = cur_v[a];  k = cur_k[a];
    end else begin
      c = prev_v[a]; k = prev_k[a];
    end
  endfunction

  function automatic void expect_out(input int n, input int hv, hf, hsw, hb, vv, vf, vsw, vb,
                                     output logic [36:0] e, output bit known);
    int ht, vt, m, p, h, v;
    logic vclk, hs, vs, bn, bz, fs;
    logic [2:0] c;
    logic [29:0] rgb;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    m  = n - (n % 2);
    vclk = ((n % 2) == 1);
    bz   = (n < CLEAR_CLKS);
    fs   = ((n % 2) == 0) && (n >= 2) && (((n / 2 - 1) % (ht * vt)) == vv * ht);
    hs = 1'b1; vs = 1'b1; bn = 1'b0; rgb = 30'd0; known = 1'b1; c = 3'b000;
    if (m >= 4) begin
      p  = m / 2 - 2;
      h  = p % ht;
      v  = (p / ht) % vt;
      hs = !((h >= hv + hf) && (h < hv + hf + hsw));
      vs = !((v >= vv + vf) && (v < vv + vf + vsw));
      bn = (h < hv) && (v < vv);
      if (bn) begin
        cell_at((v / 4) * 160 + h / 4, m, c, known);
        rgb = {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
      end
    end
    e = {vclk, hs, vs, bn, 1'b0, bz, fs, rgb};
  endfunction

  task automatic check_inst(input string tag, input logic [36:0] obs,
                            input int hv, hf, hsw, hb, vv, vf, vsw, vb);
    logic [36:0] e, mask;
    bit known;
    expect_out(n_edge, hv, hf, hsw, hb, vv, vf, vsw, vb, e, known);
    mask = known ? {37{1'b1}} : {7'h7F, 30'd0};
    chk(tag, 64'(obs & mask), 64'(e & mask));
  endtask

  task automatic do_plot(input int xi, input int yi, input logic [2:0] ci);
    int w, a;
    @(negedge clk);
    x = 8'(xi); y = 7'(yi); colour = ci; plot = 1'b1;
    @(posedge clk);
    #1;
    w = n_edge;
    if ((w > CLEAR_CLKS) && (xi < 160) && (yi < 120)) begin
      a = yi * 160 + xi;
      prev_v[a] = cur_v[a]; prev_k[a] = cur_k[a];
      cur_v[a]  = ci;       cur_k[a]  = 1'b1;
      wedge[a]  = w;
    end
    @(negedge clk);
    plot = 1'b0;
  endtask

  task automatic compare_buffer(input string tag);
    for (int a = 0; a < FB_WORDS; a++) begin
      if (cur_k[a]) begin
        chk(tag, 64'(u_big.mem[a]), 64'(cur_v[a]));
        chk(tag, 64'(u_small.mem[a]), 64'(cur_v[a]));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        check_inst("big", b_obs, 640, 16, 96, 48, 480, 10, 2, 33);
        check_inst("small", s_obs, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
      end
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // plots while the clear is running must be ignored
    for (int i = 0; i < 10; i++) begin
      do_plot(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), 3'($urandom_range(1, 7)));
    end
    while (n_edge < CLEAR_CLKS + 10) @(negedge clk);
    compare_buffer("clear_peek");

    // directed corner plots, then out-of-range plots that must be dropped
    do_plot(0, 0, 3'b100);
    do_plot(159, 119, 3'b011);
    do_plot(160, 5, 3'b111);
    do_plot(10, 120, 3'b111);
    do_plot(255, 127, 3'b110);
    chk("corner_0_0", 64'(u_small.mem[0]), 64'(3'b100));
    chk("corner_159_119", 64'(u_big.mem[19199]), 64'(3'b011));

    // random plots in the shrunken visible window and anywhere (some out of range)
    for (int i = 0; i < 30; i++) begin
      do_plot(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      repeat (int'($urandom_range(0, 40))) @(negedge clk);
    end
    for (int i = 0; i < 30; i++) begin
      do_plot(int'($urandom_range(0, 175)), int'($urandom_range(0, 127)), 3'($urandom_range(0, 7)));
    end
    repeat (7500) @(negedge clk);
    compare_buffer("plot_peek");

    // reset mid-frame and mid-clear: outputs must drop without waiting for an edge
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    while (n_edge < 5000) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_big", 64'(b_obs), 64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 30'd0}));
    chk("async_rst_small", 64'(s_obs), 64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 30'd0}));
    chk("rst_hcount", 64'(u_small.hcount_r), 64'd0);
    chk("rst_vcount", 64'(u_small.vcount_r), 64'd0);
    chk("rst_clr_addr", 64'(u_big.clr_addr_r), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    while (n_edge < CLEAR_CLKS + 3000) @(negedge clk);
    compare_buffer("reclear_peek");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
